// File: rtl/pwm_audio_dac.sv
// ---------------------------------------------------------------------------
// pwm_audio_dac
//
// Multi-channel audio output stage. One frame of CHANNELS unsigned samples is
// accepted per output period over a valid/ready handshake, the channels are
// mixed by averaging, and the mixed level drives a single 1-bit pin either as
// fixed-period PWM or as a first-order delta-sigma bitstream.
//
// The output period is 2**SAMPLE_W clock cycles. A frame accepted during a
// period is held in a one-deep pending register and becomes the active level
// at the next period boundary (the cycle where the period counter is at its
// maximum). If no frame is pending at a boundary the previous level repeats
// and an underrun pulse is produced.
//
// Parameters
//   SAMPLE_W     sample width, 4..12; output period = 2**SAMPLE_W cycles
//   CHANNELS     channels per frame, power of two, 1..8
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   s_valid      frame valid from the sample generator
//   s_ready      frame can be accepted (no frame pending)
//   s_data       channel k at [k*SAMPLE_W +: SAMPLE_W], unsigned,
//                2**(SAMPLE_W-1) is silence
//   mode         0 = PWM, 1 = delta-sigma; taken at the period boundary
//   mute         1 = output the silence level; taken at the period boundary
//   sample_tick  one-cycle pulse in the cycle where the counter is zero
//   underrun     one-cycle pulse after a boundary that found no frame pending
//   pwm          registered audio bit
// ---------------------------------------------------------------------------
module pwm_audio_dac #(
  parameter int SAMPLE_W = 8,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
  input  logic                         mode,
  input  logic                         mute,
  output logic                         sample_tick,
  output logic                         underrun,
  output logic                         pwm
);

  localparam int LOG2C = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
  localparam int SUM_W = SAMPLE_W + LOG2C;
  localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;
  localparam logic [SAMPLE_W-1:0] SILENCE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0] cnt;
  logic [SAMPLE_W-1:0] pend;
  logic                pend_full;
  logic [SAMPLE_W-1:0] active;
  logic                mode_q;
  logic                mute_q;
  logic [SAMPLE_W-1:0] acc;

  logic                boundary;
  logic                accept;
  logic [SAMPLE_W-1:0] lvl;
  logic [SAMPLE_W:0]   ds_sum;
  logic [SUM_W-1:0]    mix_sum;
  logic [SAMPLE_W-1:0] mix;

  assign boundary = (cnt == CNT_MAX);
  assign s_ready  = ~pend_full;
  assign accept   = s_valid && s_ready;
  assign lvl      = mute_q ? SILENCE : active;

  // The top bit of this sum is the delta-sigma carry; the low bits are the
  // next accumulator value.
  assign ds_sum   = {1'b0, acc} + {1'b0, lvl};

  // The sum is widened by log2(CHANNELS) bits so it cannot overflow; the
  // shift then divides by the channel count with floor rounding.
  always_comb begin
    mix_sum = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      mix_sum = mix_sum + SUM_W'(s_data[k*SAMPLE_W +: SAMPLE_W]);
    end
    mix = SAMPLE_W'(mix_sum >> LOG2C);
  end

  // Free-running period counter. The tick and underrun strobes are decoded
  // from the boundary cycle and registered, so both land in the cnt==0 cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt         <= cnt + SAMPLE_W'(1);
      sample_tick <= boundary;
      underrun    <= boundary && !pend_full;
    end
  end

  // Frame path. While a frame is pending s_ready is low, so an accept can
  // only coincide with a boundary when nothing is pending; that frame lands
  // in pend and waits a full period before it becomes active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      pend_full <= 1'b0;
      active    <= SILENCE;
    end else if (boundary && pend_full) begin
      active    <= pend;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend      <= mix;
      pend_full <= 1'b1;
    end
  end

  // Mode and mute only change on a period boundary so a period is never
  // split between two output styles or levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      mute_q <= 1'b0;
    end else if (boundary) begin
      mode_q <= mode;
      mute_q <= mute;
    end
  end

  // The accumulator only runs in delta-sigma mode and restarts from zero on
  // any mode change so a new delta-sigma run begins from a known phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (boundary && (mode != mode_q)) begin
      acc <= '0;
    end else if (mode_q) begin
      acc <= ds_sum[SAMPLE_W-1:0];
    end
  end

  // Output bit. In PWM mode the comparison against cnt gives lvl high cycles
  // followed by low cycles, delayed one cycle behind the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else if (mode_q) begin
      pwm <= ds_sum[SAMPLE_W];
    end else begin
      pwm <= (cnt < lvl);
    end
  end

endmodule

// File: tb/tb_pwm_audio_dac.sv
// ---------------------------------------------------------------------------
// tb_pwm_audio_dac
//
// Directed self-checking bench for pwm_audio_dac with SAMPLE_W=8, CHANNELS=2.
// Outputs are sampled on the falling clock edge and inputs are driven there.
// Unless noted, each test task starts and ends at the falling edge of a
// cycle where the period counter is zero (sample_tick high), so the next 256
// falling edges cover counter values 1..255,0, which is exactly one period of
// pwm bits for the level that became active at the preceding boundary.
// ---------------------------------------------------------------------------
module tb_pwm_audio_dac;

  localparam int SW = 8;
  localparam int CH = 2;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [CH*SW-1:0] s_data;
  logic          mode;
  logic          mute;
  logic          sample_tick;
  logic          underrun;
  logic          pwm;

  int checks;
  int errors;

  pwm_audio_dac #(
    .SAMPLE_W(SW),
    .CHANNELS(CH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .mode       (mode),
    .mute       (mute),
    .sample_tick(sample_tick),
    .underrun   (underrun),
    .pwm        (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge with sample_tick high, bounded.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 600);
    checks++;
    if (sample_tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tick_timeout got sample_tick=%0b want 1 within 600 cycles", sample_tick);
    end
  endtask

  // Count pwm and underrun highs over the next 256 falling edges.
  task automatic measure_period(output int highs, output int unders);
    highs  = 0;
    unders = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm === 1'b1) highs++;
      if (underrun === 1'b1) unders++;
    end
  endtask

  // Present one frame and hold it until accepted, then drop s_valid.
  // Returns at the falling edge after the accepting rising edge.
  task automatic push(input logic [SW-1:0] ch0, input logic [SW-1:0] ch1);
    int n;
    n = 0;
    s_data  = {ch1, ch0};
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (n >= 600) begin
      errors++;
      $display("[TB] FAIL push_timeout got s_ready=%0b want 1 within 600 cycles", s_ready);
    end
  endtask

  task automatic test_reset();
    int n, highs, unders;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; mode = 1'b0; mute = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwm got %0b want 0", pwm); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready got %0b want 1", s_ready); end
    checks++;
    if (sample_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %0b want 0", sample_tick); end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun got %0b want 0", underrun); end
    rst = 1'b0;
    wait_tick(n);
    checks++;
    if (n != 256) begin errors++; $display("[TB] FAIL first_tick_delay got %0d want 256", n); end
    measure_period(highs, unders);
    checks++;
    if (highs != 128) begin errors++; $display("[TB] FAIL idle_duty got %0d want 128", highs); end
    checks++;
    if (unders != 1) begin errors++; $display("[TB] FAIL idle_underrun got %0d want 1", unders); end
  endtask

  task automatic test_mix();
    int lows, unders, highs;
    push(8'd200, 8'd100);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL mix_ready_after_accept got %0b want 0", s_ready); end
    lows = 0; unders = 0;
    repeat (255) begin
      @(negedge clk);
      if (s_ready === 1'b0) lows++;
      if (underrun === 1'b1) unders++;
    end
    checks++;
    if (lows != 254) begin errors++; $display("[TB] FAIL mix_ready_low_cycles got %0d want 254", lows); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL mix_ready_after_boundary got %0b want 1", s_ready); end
    checks++;
    if (unders != 0) begin errors++; $display("[TB] FAIL mix_no_underrun got %0d want 0", unders); end
    measure_period(highs, unders);
    checks++;
    if (highs != 150) begin errors++; $display("[TB] FAIL mix_duty got %0d want 150", highs); end
    checks++;
    if (unders != 1) begin errors++; $display("[TB] FAIL mix_underrun_after got %0d want 1", unders); end
  endtask

  task automatic test_extremes();
    int n, highs, unders;
    push(8'd0, 8'd0);
    wait_tick(n);
    measure_period(highs, unders);
    checks++;
    if (highs != 0) begin errors++; $display("[TB] FAIL extreme_zero_duty got %0d want 0", highs); end
    push(8'd255, 8'd255);
    wait_tick(n);
    measure_period(highs, unders);
    checks++;
    if (highs != 255) begin errors++; $display("[TB] FAIL extreme_max_duty got %0d want 255", highs); end
    checks++;
    if (pwm !== 1'b0) begin errors++; $display("[TB] FAIL extreme_max_low_slot got %0b want 0", pwm); end
  endtask

  task automatic test_delta_sigma();
    int n, highs, unders, mism, c;
    logic expv;
    mode = 1'b1;
    push(8'd64, 8'd64);
    wait_tick(n);
    highs = 0; mism = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      c = (i + 1) % 256;
      expv = ((c % 4) == 0);
      if (pwm !== expv) mism++;
      if (pwm === 1'b1) highs++;
    end
    checks++;
    if (mism != 0) begin errors++; $display("[TB] FAIL ds_pattern got %0d wrong bits want 0", mism); end
    checks++;
    if (highs != 64) begin errors++; $display("[TB] FAIL ds_ones got %0d want 64", highs); end
    mode = 1'b0;
    measure_period(highs, unders);
    checks++;
    if (highs != 64) begin errors++; $display("[TB] FAIL ds_ones_before_switch got %0d want 64", highs); end
    @(negedge clk);
    checks++;
    if (pwm !== 1'b1) begin errors++; $display("[TB] FAIL pwm_after_switch_first got %0b want 1", pwm); end
    highs = (pwm === 1'b1) ? 1 : 0;
    repeat (255) begin
      @(negedge clk);
      if (pwm === 1'b1) highs++;
    end
    checks++;
    if (highs != 64) begin errors++; $display("[TB] FAIL pwm_after_switch_duty got %0d want 64", highs); end
  endtask

  task automatic test_back_to_back();
    int highs, accs, unders, nxt;
    bit go;
    int exp_highs[4];
    int exp_accs[4];
    exp_highs = '{64, 10, 20, 30};
    exp_accs  = '{0, 1, 1, 1};
    // Step to the boundary cycle with nothing pending so the first accept
    // lands on the boundary itself.
    repeat (255) @(negedge clk);
    nxt = 1;
    s_data  = {8'd10, 8'd10};
    s_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL b2b_boundary_accept_underrun got %0b want 1", underrun); end
    nxt = 2;
    s_data = {8'd20, 8'd20};
    for (int p = 0; p < 4; p++) begin
      highs = 0; accs = 0; unders = 0;
      for (int i = 0; i < 256; i++) begin
        go = (s_ready === 1'b1);
        @(negedge clk);
        if (go) begin
          accs++;
          nxt++;
          s_data = {8'(10 * nxt), 8'(10 * nxt)};
        end
        if (pwm === 1'b1) highs++;
        if (underrun === 1'b1) unders++;
      end
      checks++;
      if (highs != exp_highs[p]) begin errors++; $display("[TB] FAIL b2b_level_p%0d got %0d want %0d", p, highs, exp_highs[p]); end
      checks++;
      if (accs != exp_accs[p]) begin errors++; $display("[TB] FAIL b2b_accepts_p%0d got %0d want %0d", p, accs, exp_accs[p]); end
      checks++;
      if (unders != 0) begin errors++; $display("[TB] FAIL b2b_underrun_p%0d got %0d want 0", p, unders); end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_mute_and_reset();
    int n, highs, unders;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) mute = 1'b1;
      @(negedge clk);
      if (pwm === 1'b1) highs++;
    end
    checks++;
    if (highs != 40) begin errors++; $display("[TB] FAIL mute_same_period got %0d want 40", highs); end
    measure_period(highs, unders);
    checks++;
    if (highs != 128) begin errors++; $display("[TB] FAIL mute_duty got %0d want 128", highs); end
    mute = 1'b0;
    push(8'd200, 8'd200);
    repeat (76) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_pending_before got s_ready=%0b want 0", s_ready); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_s_ready got %0b want 1", s_ready); end
    checks++;
    if (pwm !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pwm got %0b want 0", pwm); end
    rst = 1'b0;
    n = 0; highs = 0;
    do begin
      @(negedge clk);
      n++;
      if (pwm === 1'b1) highs++;
    end while (sample_tick !== 1'b1 && n < 600);
    checks++;
    if (n != 256) begin errors++; $display("[TB] FAIL midrst_tick_delay got %0d want 256", n); end
    checks++;
    if (highs != 128) begin errors++; $display("[TB] FAIL midrst_first_duty got %0d want 128", highs); end
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pending_dropped got underrun=%0b want 1", underrun); end
    measure_period(highs, unders);
    checks++;
    if (highs != 128) begin errors++; $display("[TB] FAIL midrst_second_duty got %0d want 128", highs); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    mode    = 1'b0;
    mute    = 1'b0;
    $display("[TB] start");
    test_reset();
    test_mix();
    test_extremes();
    test_delta_sigma();
    test_back_to_back();
    test_mute_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
